// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and state type for the PWM generator.
// Holds default counter/dead-time widths and the IDLE/RUN state encoding.
package pwm_pkg;

  localparam int PWM_WIDTH    = 16;
  localparam int PWM_DT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary output pair with dead-time insertion.
// Ports: i_clk, i_rst (sync, active-high), i_en (generator running),
//   i_raw_next (raw PWM level about to be registered), i_deadtime,
//   o_pwm / o_pwm_n (registered, never high together).
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_raw_next,
  input  logic [DT_WIDTH-1:0] i_deadtime,
  output logic                o_pwm,
  output logic                o_pwm_n
);

  logic                lvl;
  logic                chg;
  logic [DT_WIDTH-1:0] dcnt;
  logic [DT_WIDTH-1:0] dcnt_next;
  logic                open;

  // Any raw edge (re)starts the blanking window; outputs follow the
  // raw level only once the window has fully drained.
  always_comb begin
    chg = (i_raw_next != lvl);
    dcnt_next = '0;
    if (chg) begin
      dcnt_next = i_deadtime;
    end else if (dcnt != '0) begin
      dcnt_next = dcnt - DT_WIDTH'(1);
    end
    open = (dcnt_next == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lvl     <= 1'b0;
      dcnt    <= '0;
      o_pwm   <= 1'b0;
      o_pwm_n <= 1'b0;
    end else begin
      lvl     <= i_raw_next;
      dcnt    <= dcnt_next;
      o_pwm   <= open && i_raw_next;
      // Low side stays off while the generator is idle.
      o_pwm_n <= open && i_en && !i_raw_next;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// pwm_core: tick-enabled PWM generator with double-buffered period/duty.
// Ports: i_clk, i_rst (sync, active-high), i_tick (count enable),
//   i_load/i_period/i_duty/o_load_ack (settings handshake),
//   o_period_end (wrap strobe), o_pwm (registered PWM).
// Macro PWM_COMPL_EN adds i_deadtime and o_pwm_n (dead-time pair).
module pwm_core
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
`ifdef PWM_COMPL_EN
  ,
  parameter int DT_WIDTH = PWM_DT_WIDTH
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_duty,
  output logic             o_load_ack,
  output logic             o_period_end,
  output logic             o_pwm
`ifdef PWM_COMPL_EN
  ,
  input  logic [DT_WIDTH-1:0] i_deadtime,
  output logic                o_pwm_n
`endif
);

  pwm_state_t state;
  pwm_state_t state_next;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] per;
  logic [WIDTH-1:0] per_next;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] duty_next;
  logic [WIDTH-1:0] pper;
  logic [WIDTH-1:0] pduty;
  logic             pv;
  logic             ack;
  logic             wrap;
  logic             xfer;
  logic             raw_next;

  always_comb begin
    ack  = i_load && !pv && !i_rst;
    // per is never 0 in RUN, so per-1 cannot underflow here.
    wrap = (state == RUN) && i_tick &&
           (cnt == per - WIDTH'(1));
    xfer = pv && ((state == IDLE) || wrap);

    cnt_next   = cnt;
    per_next   = per;
    duty_next  = duty;
    state_next = state;

    if (xfer) begin
      cnt_next   = '0;
      per_next   = pper;
      duty_next  = pduty;
      state_next = (pper != '0) ? RUN : IDLE;
    end else if (wrap) begin
      cnt_next = '0;
    end else if ((state == RUN) && i_tick) begin
      cnt_next = cnt + WIDTH'(1);
    end

    // Output is computed from next-state values so it moves on the
    // same edge as the counter it reflects.
    raw_next = (state_next == RUN) && (cnt_next < duty_next);
  end

  assign o_load_ack = ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      per          <= '0;
      duty         <= '0;
      pper         <= '0;
      pduty        <= '0;
      pv           <= 1'b0;
      o_period_end <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      per          <= per_next;
      duty         <= duty_next;
      o_period_end <= wrap;
      if (xfer) begin
        pv <= 1'b0;
      end else if (ack) begin
        pv <= 1'b1;
      end
      if (ack) begin
        pper  <= i_period;
        pduty <= i_duty;
      end
    end
  end

`ifdef PWM_COMPL_EN
  pwm_deadtime #(
    .DT_WIDTH(DT_WIDTH)
  ) u_dt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (state_next == RUN),
    .i_raw_next(raw_next),
    .i_deadtime(i_deadtime),
    .o_pwm     (o_pwm),
    .o_pwm_n   (o_pwm_n)
  );
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pwm <= 1'b0;
    end else begin
      o_pwm <= raw_next;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed self-checking bench for pwm_core.
// Inputs change at posedge+1, registered outputs are sampled there too.
module tb_pwm_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] duty = '0;
  logic        ack;
  logic        pe;
  logic        pwm;
`ifdef PWM_COMPL_EN
  logic [7:0]  dt = '0;
  logic        pwm_n;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_core dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_load      (load),
    .i_period    (period),
    .i_duty      (duty),
    .o_load_ack  (ack),
    .o_period_end(pe),
    .o_pwm       (pwm)
`ifdef PWM_COMPL_EN
    ,
    .i_deadtime  (dt),
    .o_pwm_n     (pwm_n)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    tick = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Hold a request until acked; returns at posedge+1 after capture.
  task automatic load_req(input int p, input int d);
    int w;
    w = 0;
    load   = 1'b1;
    period = 16'(p);
    duty   = 16'(d);
    #1;
    while (ack !== 1'b1 && w < 40) begin
      @(posedge clk);
      #2;
      w++;
    end
    tests++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL load_ack: ack=%b required 1 (waited %0d)", ack, w);
    end
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    load = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({pwm, pe, ack} !== 3'b000) begin
        fails++;
        $display("FAIL reset_hold: pwm/pe/ack=%b required 000",
                 {pwm, pe, ack});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      tests++;
      if ({pwm, pe, ack} !== 3'b000) begin
        fails++;
        $display("FAIL idle_%0d: pwm/pe/ack=%b required 000",
                 i, {pwm, pe, ack});
      end
    end
  endtask

  // Ticks on every tdiv-th cycle; ecnt tracks the expected counter.
  task automatic test_waveform(input int p, input int d,
                               input int tdiv, input int n);
    int  ecnt;
    logic epe;
    logic epwm;
    do_reset();
    load_req(p, d);
    tests++;
    if (pwm !== 1'b0) begin
      fails++;
      $display("FAIL lat1 P=%0d D=%0d: pwm=%b required 0", p, d, pwm);
    end
    step();
    ecnt = 0;
    epwm = (d > 0);
    tests++;
    if (pwm !== epwm || pe !== 1'b0) begin
      fails++;
      $display("FAIL lat2 P=%0d D=%0d: pwm=%b pe=%b required %b 0",
               p, d, pwm, pe, epwm);
    end
    for (int j = 0; j < n; j++) begin
      tick = (j % tdiv == 0);
      epe = tick && (ecnt == p - 1);
      if (tick) ecnt = epe ? 0 : ecnt + 1;
      epwm = (ecnt < d);
      step();
      tests++;
      if (pwm !== epwm || pe !== epe) begin
        fails++;
        $display("FAIL wave P=%0d D=%0d j=%0d: pwm=%b pe=%b required %b %b",
                 p, d, j, pwm, pe, epwm, epe);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_buffered();
    logic epwm;
    logic epe;
    logic eack;
    do_reset();
    tick = 1'b1;
    load_req(10, 3);
    step();
    for (int k = 0; k < 26; k++) begin
      if (k < 10)      epwm = (k % 10) < 3;
      else if (k < 14) epwm = ((k - 10) % 4) < 2;
      else             epwm = 1'b1;
      epe = (k == 10) || (k == 14) || (k == 20);
      tests++;
      if (pwm !== epwm || pe !== epe) begin
        fails++;
        $display("FAIL buf k=%0d: pwm=%b pe=%b required %b %b",
                 k, pwm, pe, epwm, epe);
      end
      load = (k == 5) || (k >= 7 && k <= 10);
      period = (k == 5) ? 16'd4 : 16'd6;
      duty   = (k == 5) ? 16'd2 : 16'd6;
      eack = (k == 5) || (k == 10);
      #1;
      tests++;
      if (ack !== eack) begin
        fails++;
        $display("FAIL buf_ack k=%0d: ack=%b required %b", k, ack, eack);
      end
      step();
    end
    load = 1'b0;
    tick = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick = 1'b1;
    load_req(10, 3);
    step();
    for (int k = 0; k < 5; k++) step();
    load   = 1'b1;
    period = 16'd4;
    duty   = 16'd2;
    #1;
    tests++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL mid_ack: ack=%b required 1", ack);
    end
    step();
    load = 1'b0;
    rst  = 1'b1;
    #1;
    tests++;
    if (ack !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_ack: ack=%b required 0", ack);
    end
    step();
    tests++;
    if (pwm !== 1'b0 || pe !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_out: pwm=%b pe=%b required 0 0", pwm, pe);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if (pwm !== 1'b0 || pe !== 1'b0) begin
        fails++;
        $display("FAIL mid_idle_%0d: pwm=%b pe=%b required 0 0",
                 i, pwm, pe);
      end
    end
    load   = 1'b1;
    period = 16'd4;
    duty   = 16'd2;
    #1;
    tests++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL mid_pv_clear: ack=%b required 1", ack);
    end
    step();
    load = 1'b0;
    tick = 1'b0;
  endtask

`ifdef PWM_COMPL_EN
  task automatic test_deadtime(input int d8, input int hexp,
                               input int nexp, input int hmin);
    int hrun;
    int nrun;
    int hcnt;
    int ncnt;
    hrun = 0;
    nrun = 0;
    hcnt = 0;
    ncnt = 0;
    dt = 8'(d8);
    do_reset();
    tick = 1'b1;
    load_req(20, 8);
    for (int j = 0; j < 80; j++) begin
      step();
      tests++;
      if (pwm === 1'b1 && pwm_n === 1'b1) begin
        fails++;
        $display("FAIL dt_overlap j=%0d: pwm=1 pwm_n=1 required not both", j);
      end
      if (pwm === 1'b1) hrun++;
      else if (hrun > 0) begin
        tests++;
        hcnt++;
        if (hrun != hexp) begin
          fails++;
          $display("FAIL dt_hi_run: %0d required %0d", hrun, hexp);
        end
        hrun = 0;
      end
      if (pwm_n === 1'b1) nrun++;
      else if (nrun > 0) begin
        tests++;
        ncnt++;
        if (nrun != nexp) begin
          fails++;
          $display("FAIL dt_lo_run: %0d required %0d", nrun, nexp);
        end
        nrun = 0;
      end
    end
    tests++;
    if (hcnt < hmin || ncnt < 2 || (hmin == 0 && (hcnt + hrun) != 0)) begin
      fails++;
      $display("FAIL dt_runs: hi=%0d lo=%0d required hi>=%0d lo>=2",
               hcnt, ncnt, hmin);
    end
    tick = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_waveform(10, 3, 1, 30);
    test_waveform(10, 0, 1, 25);
    test_waveform(10, 10, 1, 25);
    test_waveform(10, 15, 1, 25);
    test_waveform(1, 1, 1, 12);
    test_waveform(4, 2, 3, 30);
    test_buffered();
    test_reset_mid();
`ifdef PWM_COMPL_EN
    test_deadtime(2, 6, 10, 2);
    test_deadtime(10, 0, 2, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pwm_core.md
# pwm_core

PWM generator stage that consumes the enable tick produced by the even-ratio clock divider in the PWM path and produces the PWM waveform. It has a free-running period counter, double-buffered period/duty registers with a load handshake, and a period-end strobe. It runs entirely on the system clock. The divider output is used only as a count enable, never as a clock.

## Interface
- WIDTH, 16, width of the period, duty and counter values
- DT_WIDTH, 8, width of the dead-time count (used only with PWM_COMPL_EN)

- i_clk  in  1  system clock; all logic on posedge
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_tick  in  1  count enable from the divider, one i_clk wide per divided period
- i_load  in  1  request to stage new settings; held until o_load_ack
- i_period  in  WIDTH  new period in ticks; sampled when o_load_ack=1
- i_duty  in  WIDTH  new high time in ticks; sampled when o_load_ack=1
- o_load_ack  out  1  one-cycle pulse; settings captured into pending buffer
- o_period_end  out  1  one-cycle pulse when the counter wraps
- o_pwm  out  1  PWM output, registered
- i_deadtime  in  DT_WIDTH  dead time in i_clk cycles (PWM_COMPL_EN only)
- o_pwm_n  out  1  complementary output, registered (PWM_COMPL_EN only)

## Operation
- Registers: counter cnt, active period P and duty D, pending period/duty, pending-valid flag pv, state.
- States:
  - IDLE: entered when P=0, including after reset.
  - RUN: entered when P≠0.
- Load handshake:
  - When i_load=1 and pv=0, capture i_period/i_duty into pending, set pv, and pulse o_load_ack in the same cycle.
  - When pv=1, i_load is back-pressured and no ack is given.
  - An upstream that drops i_load before ack has its request discarded.
- Pending → active transfer:
  - In IDLE: on the cycle after pv is set, regardless of i_tick.
  - In RUN: only on a wrap tick.
  - Transfer clears pv. cnt restarts at 0. State is re-evaluated from the new P.
- Counting, RUN only, on i_tick=1:
  - If cnt = P−1: cnt←0, o_period_end←1, apply pending if pv.
  - Otherwise cnt←cnt+1.
  - When i_tick=0, cnt holds.
- Output: o_pwm ← (state=RUN) && (cnt_next < D_next), evaluated every i_clk.
  - D=0 gives constant low.
  - D ≥ P gives constant high, with no glitch at wrap.
- P=1: cnt stays 0 and o_period_end pulses on every tick.
- Arithmetic is unsigned WIDTH-bit. The P−1 compare needs no wrap because P=0 never runs.
- Simultaneous i_load and wrap tick with pv=1: the transfer happens first, and the ack is given on the next cycle (pv=0 then).
- Reset mid-operation: pending is discarded, no ack is issued, and all outputs are low in the cycle after i_rst.

## Timing
- Reset values: cnt=0, P=D=0, pv=0, state=IDLE, o_pwm=0, o_pwm_n=0, o_load_ack=0, o_period_end=0.
- o_pwm and o_period_end change on the same i_clk edge as the cnt update they reflect (zero added latency relative to the tick).
- Load-to-output latency:
  - From IDLE: 2 i_clk cycles from ack to the first o_pwm high.
  - From RUN: up to P ticks (until the next wrap).
- i_tick is assumed synchronous to i_clk. A tick held high for several cycles counts once per cycle.

## Configuration
- PWM_COMPL_EN defined: o_pwm_n and i_deadtime exist.
  - o_pwm_n is the complement of the raw PWM.
  - On every raw edge both outputs are held low for i_deadtime i_clk cycles, then the new level's output rises.
  - A raw edge during dead time restarts the dead-time count. Pulses shorter than the dead time are swallowed.
  - i_deadtime=0 gives exact complements.
  - o_pwm and o_pwm_n are never high together.
- PWM_COMPL_EN undefined: the ports are absent, o_pwm is the raw registered PWM, and no dead-time logic is present.

## Structure
- Package pwm_pkg: default WIDTH and DT_WIDTH constants, and the state typedef (IDLE, RUN).
- Sub-module pwm_deadtime: raw PWM in, o_pwm/o_pwm_n out. Instantiated only under PWM_COMPL_EN.

## Test plan
- Reset and idle: hold i_rst 3 cycles, keep i_load=0 → all outputs stay 0 and no o_period_end over 50 ticks.
- Basic waveform: load P=10, D=3, tick every cycle → o_pwm high 3 cycles, low 7 cycles, repeating; o_period_end once per 10.
- Boundary duties: D=0 → o_pwm always 0. D=10 or D=15 with P=10 → always 1 with no low cycle at wrap. P=1, D=1 → constant high and o_period_end every tick.
- Buffered update: while running P=10/D=3, load P=4/D=2 at cnt=5 → ack immediately, old waveform finishes, new pattern starts exactly at the wrap. A second load before the wrap gets no ack until after the transfer.
- Reset mid-period: assert i_rst at cnt=6 with a pending load → outputs 0 next cycle, pv cleared, stays IDLE.
- PWM_COMPL_EN: P=20, D=8, deadtime=2 → o_pwm high 6 cycles, o_pwm_n high 10 cycles, 2-cycle both-low gaps, never both high. With deadtime=10, D=8 → o_pwm never rises.
